// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_predictor                                                |
// | Purpose  : Direct-mapped BTB with 2-bit saturating counters. Fetch looks   |
// |            up IF_PC combinationally and gets predict_taken/predict_PC; the |
// |            table is trained at the clock edge from EX branch resolution.   |
// | Ports    : clk, rst            - clock, synchronous active-high reset       |
// |            IF_PC               - PC currently in fetch                      |
// |            predict_taken       - fetch predicts taken                       |
// |            predict_PC          - next fetch PC (target or IF_PC+4)          |
// |            EX_is_branch        - update strobe from EX                      |
// |            EX_PC, EX_taken     - resolved PC and actual direction           |
// |            EX_target           - resolved taken target                      |
// |            EX_mispredict       - redirect in progress (statistics only)     |
// |            EX_stall            - EX frozen, update suppressed               |
// |            stat_branches       - resolved-branch count   (BP_STATS_EN only) |
// |            stat_mispredicts    - mispredict count        (BP_STATS_EN only) |
// | Options  : define BP_STATS_EN to add the two statistics counters.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module branch_predictor #(
  parameter int         IDX_BITS  = 6,
  parameter int         TAG_BITS  = 8,
  parameter logic [1:0] RESET_CTR = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_PC,
  output logic        predict_taken,
  output logic [31:0] predict_PC,
  input  logic        EX_is_branch,
  input  logic [31:0] EX_PC,
  input  logic        EX_taken,
  input  logic [31:0] EX_target,
  input  logic        EX_mispredict,
  input  logic        EX_stall
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_LO  = IDX_BITS + 2;
  localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

  // Table storage kept in flops so lookup is purely combinational.
  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];

  // ---------------------------------------------------------------- lookup
  logic [IDX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0] w_if_tag;
  logic                w_if_hit;

  assign w_if_idx = IF_PC[IDX_BITS+1:2];
  assign w_if_tag = IF_PC[TAG_HI:TAG_LO];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

  assign predict_taken = w_if_hit && r_ctr[w_if_idx][1];
  // 32-bit addition wraps naturally from 0xFFFFFFFC to 0x00000000.
  assign predict_PC    = predict_taken ? r_target[w_if_idx] : (IF_PC + 32'd4);

  // ---------------------------------------------------------------- update
  logic [IDX_BITS-1:0] w_ex_idx;
  logic [TAG_BITS-1:0] w_ex_tag;
  logic                w_ex_hit;
  logic                w_upd;
  logic [1:0]          w_ctr_cur;
  logic [1:0]          w_ctr_next;

  assign w_ex_idx  = EX_PC[IDX_BITS+1:2];
  assign w_ex_tag  = EX_PC[TAG_HI:TAG_LO];
  assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_upd     = EX_is_branch && !EX_stall;
  assign w_ctr_cur = r_ctr[w_ex_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (EX_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
    end
  end

  // Reset has priority over any same-cycle training. Tags and targets are
  // left unreset because valid=0 masks them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (w_upd) begin
      if (w_ex_hit) begin
        r_ctr[w_ex_idx] <= w_ctr_next;
        if (EX_taken) r_target[w_ex_idx] <= EX_target;
      end else if (EX_taken) begin
        // Miss on a taken branch allocates, evicting any aliasing entry.
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= EX_target;
        r_ctr[w_ex_idx]    <= RESET_CTR;
      end
    end
  end

  // ------------------------------------------------------------ statistics
`ifdef BP_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_branches    <= 32'd0;
      r_stat_mispredicts <= 32'd0;
    end else if (w_upd) begin
      r_stat_branches <= r_stat_branches + 32'd1;
      if (EX_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;

  logic w_unused;
  assign w_unused = ^{IF_PC[1:0], EX_PC[1:0], EX_PC[31:TAG_HI+1]};
`else
  // Without statistics the mispredict flag has no consumer.
  logic w_unused;
  assign w_unused = ^{IF_PC[1:0], EX_PC[1:0], EX_PC[31:TAG_HI+1], EX_mispredict};
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_branch_predictor                                             |
// | Purpose  : Self-checking bench for branch_predictor. Expected lookup and   |
// |            statistics values are pushed to a scoreboard queue as stimulus  |
// |            is applied and popped when the DUT output is sampled.           |
// | Options  : define BP_STATS_EN to also exercise the statistics counters.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_PC;
  logic        predict_taken;
  logic [31:0] predict_PC;
  logic        EX_is_branch;
  logic [31:0] EX_PC;
  logic        EX_taken;
  logic [31:0] EX_target;
  logic        EX_mispredict;
  logic        EX_stall;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .IF_PC         (IF_PC),
    .predict_taken (predict_taken),
    .predict_PC    (predict_PC),
    .EX_is_branch  (EX_is_branch),
    .EX_PC         (EX_PC),
    .EX_taken      (EX_taken),
    .EX_target     (EX_target),
    .EX_mispredict (EX_mispredict),
    .EX_stall      (EX_stall)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    bit          upd;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
    logic        et;
    logic [31:0] ep;
  } step_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Drives one EX resolution for exactly one rising edge.
  task automatic do_update(input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic stall,
                           input logic mis);
    @(negedge clk);
    EX_is_branch  = 1'b1;
    EX_PC         = pc;
    EX_taken      = taken;
    EX_target     = tgt;
    EX_stall      = stall;
    EX_mispredict = mis;
    @(negedge clk);
    EX_is_branch  = 1'b0;
    EX_stall      = 1'b0;
    EX_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    IF_PC = 32'h1C00_0000;
    sb.push_back('{1'b0, 32'h1C00_0004});
    #1;
    e = sb.pop_front();
    total++;
    if (predict_taken !== e.taken || predict_PC !== e.pc) begin
      bad++;
      $display("FAIL reset_in: got taken=%b pc=%h want taken=%b pc=%h",
               predict_taken, predict_PC, e.taken, e.pc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    IF_PC = 32'hFFFF_FFFC;  // miss path also exercises PC+4 wraparound
    sb.push_back('{1'b0, 32'h0000_0000});
    #1;
    e = sb.pop_front();
    total++;
    if (predict_taken !== e.taken || predict_PC !== e.pc) begin
      bad++;
      $display("FAIL reset_wrap: got taken=%b pc=%h want taken=%b pc=%h",
               predict_taken, predict_PC, e.taken, e.pc);
    end
`ifdef BP_STATS_EN
    total++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      bad++;
      $display("FAIL reset_stats: got br=%0d mis=%0d want 0 0",
               stat_branches, stat_mispredicts);
    end
`endif
  endtask

  task automatic test_counter();
    step_t st[$];
    exp_t  e;
    st.push_back('{1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0100, 1'b0, 32'h0});          // alloc 10
    st.push_back('{1'b0, 32'h1C00_0010, 1'b0, 32'h0,         1'b1, 32'h1C00_0100});
    st.push_back('{1'b0, 32'h1C00_0013, 1'b0, 32'h0,         1'b1, 32'h1C00_0100}); // low bits ignored
    st.push_back('{1'b1, 32'h1C00_0010, 1'b0, 32'h0,         1'b0, 32'h0});          // 01
    st.push_back('{1'b0, 32'h1C00_0010, 1'b0, 32'h0,         1'b0, 32'h1C00_0014});
    st.push_back('{1'b1, 32'h1C00_0010, 1'b0, 32'h0,         1'b0, 32'h0});          // 00
    st.push_back('{1'b1, 32'h1C00_0010, 1'b0, 32'h0,         1'b0, 32'h0});          // 00 sat
    st.push_back('{1'b0, 32'h1C00_0010, 1'b0, 32'h0,         1'b0, 32'h1C00_0014});
    st.push_back('{1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0100, 1'b0, 32'h0});          // 01
    st.push_back('{1'b0, 32'h1C00_0010, 1'b0, 32'h0,         1'b0, 32'h1C00_0014});
    st.push_back('{1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0100, 1'b0, 32'h0});          // 10
    st.push_back('{1'b0, 32'h1C00_0010, 1'b0, 32'h0,         1'b1, 32'h1C00_0100});
    st.push_back('{1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0100, 1'b0, 32'h0});          // 11
    st.push_back('{1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0100, 1'b0, 32'h0});          // 11 sat
    st.push_back('{1'b1, 32'h1C00_0010, 1'b0, 32'h0,         1'b0, 32'h0});          // 10
    st.push_back('{1'b0, 32'h1C00_0010, 1'b0, 32'h0,         1'b1, 32'h1C00_0100});
    st.push_back('{1'b0, 32'h1C00_0013, 1'b0, 32'h0,         1'b1, 32'h1C00_0100});
    foreach (st[i]) begin
      if (st[i].upd) begin
        do_update(st[i].pc, st[i].taken, st[i].tgt, 1'b0, 1'b0);
      end else begin
        IF_PC = st[i].pc;
        sb.push_back('{st[i].et, st[i].ep});
        #1;
        e = sb.pop_front();
        total++;
        if (predict_taken !== e.taken || predict_PC !== e.pc) begin
          bad++;
          $display("FAIL counter[%0d]: got taken=%b pc=%h want taken=%b pc=%h",
                   i, predict_taken, predict_PC, e.taken, e.pc);
        end
      end
    end
  endtask

  task automatic test_alias();
    step_t st[$];
    exp_t  e;
    st.push_back('{1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0200, 1'b0, 32'h0});          // hit, new target
    st.push_back('{1'b0, 32'h1C00_0010, 1'b0, 32'h0,         1'b1, 32'h1C00_0200});
    st.push_back('{1'b0, 32'h1C00_0110, 1'b0, 32'h0,         1'b0, 32'h1C00_0114}); // alias miss
    st.push_back('{1'b1, 32'h1C00_0110, 1'b1, 32'h1C00_0400, 1'b0, 32'h0});          // replace
    st.push_back('{1'b0, 32'h1C00_0010, 1'b0, 32'h0,         1'b0, 32'h1C00_0014});
    st.push_back('{1'b0, 32'h1C00_0110, 1'b0, 32'h0,         1'b1, 32'h1C00_0400});
    st.push_back('{1'b1, 32'h1C00_0050, 1'b0, 32'h0,         1'b0, 32'h0});          // NT miss
    st.push_back('{1'b0, 32'h1C00_0050, 1'b0, 32'h0,         1'b0, 32'h1C00_0054});
    st.push_back('{1'b1, 32'h1C00_0050, 1'b1, 32'h1C00_0800, 1'b0, 32'h0});          // alloc
    st.push_back('{1'b0, 32'h1C00_0050, 1'b0, 32'h0,         1'b1, 32'h1C00_0800});
    foreach (st[i]) begin
      if (st[i].upd) begin
        do_update(st[i].pc, st[i].taken, st[i].tgt, 1'b0, 1'b0);
      end else begin
        IF_PC = st[i].pc;
        sb.push_back('{st[i].et, st[i].ep});
        #1;
        e = sb.pop_front();
        total++;
        if (predict_taken !== e.taken || predict_PC !== e.pc) begin
          bad++;
          $display("FAIL alias[%0d]: got taken=%b pc=%h want taken=%b pc=%h",
                   i, predict_taken, predict_PC, e.taken, e.pc);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    @(negedge clk);
    IF_PC         = 32'h1C00_0020;
    EX_is_branch  = 1'b1;
    EX_PC         = 32'h1C00_0020;
    EX_taken      = 1'b1;
    EX_target     = 32'h1C00_0300;
    sb.push_back('{1'b0, 32'h1C00_0024});
    #1;
    e = sb.pop_front();
    total++;
    if (predict_taken !== e.taken || predict_PC !== e.pc) begin
      bad++;
      $display("FAIL same_cycle_pre: got taken=%b pc=%h want taken=%b pc=%h",
               predict_taken, predict_PC, e.taken, e.pc);
    end
    @(negedge clk);
    EX_is_branch = 1'b0;
    sb.push_back('{1'b1, 32'h1C00_0300});
    #1;
    e = sb.pop_front();
    total++;
    if (predict_taken !== e.taken || predict_PC !== e.pc) begin
      bad++;
      $display("FAIL same_cycle_post: got taken=%b pc=%h want taken=%b pc=%h",
               predict_taken, predict_PC, e.taken, e.pc);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    // Stalled NT on a weakly-taken hit must leave the counter at 10.
    do_update(32'h1C00_0020, 1'b0, 32'h0, 1'b1, 1'b0);
    // Stalled taken miss must not allocate.
    do_update(32'h1C00_0030, 1'b1, 32'h1C00_0500, 1'b1, 1'b0);
    IF_PC = 32'h1C00_0020;
    sb.push_back('{1'b1, 32'h1C00_0300});
    #1;
    e = sb.pop_front();
    total++;
    if (predict_taken !== e.taken || predict_PC !== e.pc) begin
      bad++;
      $display("FAIL stall_hit: got taken=%b pc=%h want taken=%b pc=%h",
               predict_taken, predict_PC, e.taken, e.pc);
    end
    IF_PC = 32'h1C00_0030;
    sb.push_back('{1'b0, 32'h1C00_0034});
    #1;
    e = sb.pop_front();
    total++;
    if (predict_taken !== e.taken || predict_PC !== e.pc) begin
      bad++;
      $display("FAIL stall_miss: got taken=%b pc=%h want taken=%b pc=%h",
               predict_taken, predict_PC, e.taken, e.pc);
    end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    @(negedge clk);
    rst          = 1'b1;
    EX_is_branch = 1'b1;
    EX_PC        = 32'h1C00_0040;
    EX_taken     = 1'b1;
    EX_target    = 32'h1C00_0600;
    @(negedge clk);
    rst          = 1'b0;
    EX_is_branch = 1'b0;
    IF_PC = 32'h1C00_0040;
    sb.push_back('{1'b0, 32'h1C00_0044});
    #1;
    e = sb.pop_front();
    total++;
    if (predict_taken !== e.taken || predict_PC !== e.pc) begin
      bad++;
      $display("FAIL rst_no_alloc: got taken=%b pc=%h want taken=%b pc=%h",
               predict_taken, predict_PC, e.taken, e.pc);
    end
    IF_PC = 32'h1C00_0020;
    sb.push_back('{1'b0, 32'h1C00_0024});
    #1;
    e = sb.pop_front();
    total++;
    if (predict_taken !== e.taken || predict_PC !== e.pc) begin
      bad++;
      $display("FAIL rst_cleared: got taken=%b pc=%h want taken=%b pc=%h",
               predict_taken, predict_PC, e.taken, e.pc);
    end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    exp_t e;
    do_reset();
    do_update(32'h1C00_0060, 1'b1, 32'h1C00_0700, 1'b0, 1'b1);
    do_update(32'h1C00_0064, 1'b0, 32'h0,         1'b0, 1'b0);
    do_update(32'h1C00_0068, 1'b1, 32'h1C00_0710, 1'b1, 1'b1);  // stalled: not counted
    do_update(32'h1C00_0060, 1'b0, 32'h0,         1'b0, 1'b1);
    do_update(32'h1C00_006C, 1'b1, 32'h1C00_0720, 1'b0, 1'b0);
    do_update(32'h1C00_0060, 1'b1, 32'h1C00_0700, 1'b0, 1'b0);
    // The scoreboard reuses exp_t: taken field unused, pc holds a count.
    sb.push_back('{1'b0, 32'd5});
    sb.push_back('{1'b0, 32'd2});
    #1;
    e = sb.pop_front();
    total++;
    if (stat_branches !== e.pc) begin
      bad++;
      $display("FAIL stat_branches: got %0d want %0d", stat_branches, e.pc);
    end
    e = sb.pop_front();
    total++;
    if (stat_mispredicts !== e.pc) begin
      bad++;
      $display("FAIL stat_mispredicts: got %0d want %0d", stat_mispredicts, e.pc);
    end
    do_reset();
    #1;
    total++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      bad++;
      $display("FAIL stat_reset: got br=%0d mis=%0d want 0 0",
               stat_branches, stat_mispredicts);
    end
  endtask
`endif

  initial begin
    rst           = 1'b1;
    IF_PC         = 32'h0;
    EX_is_branch  = 1'b0;
    EX_PC         = 32'h0;
    EX_taken      = 1'b0;
    EX_target     = 32'h0;
    EX_mispredict = 1'b0;
    EX_stall      = 1'b0;
    test_reset();
    test_counter();
    test_alias();
    test_same_cycle();
    test_stall();
    test_reset_priority();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side producer of the `predict` bit consumed by the execute stage.
- Also the consumer of execute-stage branch resolution.
- Direct-mapped BTB with 2-bit saturating counters: looks up IF_PC combinationally, drives predict_taken/predict_PC to fetch, and is trained at the clock edge from EX resolution (taken, target, mispredict).

Parameters:
IDX_BITS, 6, log2 of entry count (64 entries); index = PC[IDX_BITS+1:2]
TAG_BITS, 8, tag width; tag = PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2]
RESET_CTR, 2'b10, counter value written on allocation (weakly taken)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
IF_PC  input  32  PC currently in fetch
predict_taken  output  1  fetch predicts taken; travels down pipe to EX `predict`
predict_PC  output  32  next fetch PC: target if predict_taken, else IF_PC+4
EX_is_branch  input  1  EX holds a resolved conditional branch/jump this cycle (update strobe)
EX_PC  input  32  PC of the resolved instruction
EX_taken  input  1  actual direction resolved in EX
EX_target  input  32  actual taken target (EX_PC_out when taken)
EX_mispredict  input  1  EX_Branch_out; redirect/flush in progress
EX_stall  input  1  EX frozen; update suppressed

Behaviour:
- Storage per entry: valid(1), tag(TAG_BITS), target(32), ctr(2). No RAM macro; flops.
- Reset (synchronous, rst=1 at posedge): all valid <= 0, all ctr <= 2'b01, targets/tags don't-care.
  - Outputs during/after reset are combinational results of a miss: predict_taken=0, predict_PC=IF_PC+4.
- Lookup (combinational, 0 latency):
  - hit = valid[idx] && tag[idx]==IF_PC tag.
  - predict_taken = hit && ctr[idx][1].
  - predict_PC = predict_taken ? target[idx] : IF_PC+4, 32-bit wraparound (0xFFFFFFFC -> 0x00000000).
- Update at posedge, only when EX_is_branch && !EX_stall && !rst:
  - Hit at EX_PC:
    - ctr saturating +1 if EX_taken (max 2'b11), -1 if not taken (min 2'b00).
    - If EX_taken, target <= EX_target.
  - Miss at EX_PC, EX_taken=1: allocate/overwrite entry. valid<=1, tag<=EX_PC tag, target<=EX_target, ctr<=RESET_CTR.
  - Miss at EX_PC, EX_taken=0: no state change.
- EX_mispredict does not alter table logic; it exists for the optional statistics and for a consistency check.
- Same-cycle lookup and update to one index: lookup returns pre-update contents; new contents visible the following cycle.
- Aliasing: different tag, same index -> miss on lookup; a taken resolution replaces the entry.
- Reset asserted mid-training: reset wins over any same-cycle update.
- Low PC bits [1:0] ignored.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Incremented at posedge when EX_is_branch && !EX_stall; stat_mispredicts also requires EX_mispredict.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; table behaviour identical.

Test Plan:
- Reset, IF_PC=0x1C000000 -> predict_taken=0, predict_PC=0x1C000004 (all entries invalid).
- Update EX_PC=0x1C000010 taken, EX_target=0x1C000100; next cycle IF_PC=0x1C000010 -> predict_taken=1, predict_PC=0x1C000100 (ctr=10).
- Then one not-taken update at 0x1C000010 -> ctr=01; lookup gives predict_PC=0x1C000014. Two more not-taken -> ctr stays 00. Three taken -> 11, a fourth stays 11.
- Alias: train 0x1C000010 taken; lookup 0x1C000110 (same index, different tag) -> miss, PC+4. Taken update at 0x1C000110, target 0x1C000400 -> lookup 0x1C000010 now misses.
- Same-cycle: IF_PC=EX_PC=0x1C000020, first taken update -> that cycle predict_taken=0; next cycle 1. Update with EX_stall=1 -> no change. rst with EX_is_branch=1 -> table cleared, no allocation.
- BP_STATS_EN: 5 resolutions, 2 with EX_mispredict=1 -> stat_branches=5, stat_mispredicts=2. Reset -> both 0.
